// File: rtl/gesture_pkg.sv
// Shared constants for the gesture pipeline: finger count, finger ordering and default ADC width.
package gesture_pkg;
    localparam int NUM_FINGERS = 5;
    localparam int THUMB       = 0;
    localparam int INDEX       = 1;
    localparam int MIDDLE      = 2;
    localparam int RING        = 3;
    localparam int PINKY       = 4;
    localparam int ADC_W_DEF   = 8;
endpackage

// File: rtl/finger_debounce.sv
// One finger: hysteresis threshold plus consecutive-sample debounce of a flex reading.
// Status updates on the edge that takes the STABLE_COUNT-th disagreeing strobe; no backpressure.
module finger_debounce #(
    parameter int ADC_W        = 8,
    parameter int BEND_HI      = 160,
    parameter int BEND_LO      = 96,
    parameter int STABLE_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid_i,
    input  logic [ADC_W-1:0] sample_i,
    output logic             status_o,
    output logic             flip_o,
    output logic             cnt_zero_o
);
    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [ADC_W-1:0] HI   = ADC_W'(BEND_HI);
    localparam logic [ADC_W-1:0] LO   = ADC_W'(BEND_LO);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

    logic             status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw;

    // Inside the dead band the reading simply agrees with the current status.
    always_comb begin
        raw = status_q;
        if (sample_i >= HI)
            raw = 1'b1;
        else if (sample_i <= LO)
            raw = 1'b0;
    end

    always_comb begin
        status_d = status_q;
        cnt_d    = cnt_q;
        if (sample_valid_i) begin
            if (raw == status_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                status_d = raw;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign status_o   = status_q;
    assign flip_o     = status_d != status_q;
    assign cnt_zero_o = cnt_d == '0;
endmodule

// File: rtl/finger_status_conditioner.sv
// Five debounced bent/extended finger bits plus change pulse and hand-stable flag.
// Status visible the cycle after the deciding strobe edge; strobes may be back-to-back, no backpressure.
module finger_status_conditioner
    import gesture_pkg::*;
#(
    parameter int ADC_W        = ADC_W_DEF,
    parameter int BEND_HI      = 160,
    parameter int BEND_LO      = 96,
    parameter int STABLE_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] thumb_sample,
    input  logic [ADC_W-1:0] index_sample,
    input  logic [ADC_W-1:0] middle_sample,
    input  logic [ADC_W-1:0] ring_sample,
    input  logic [ADC_W-1:0] pinky_sample,
    output logic             thumb_status,
    output logic             index_status,
    output logic             middle_status,
    output logic             ring_status,
    output logic             pinky_status,
    output logic             status_changed,
    output logic             hand_stable
);
    logic [ADC_W-1:0]       sample_arr [NUM_FINGERS];
    logic [NUM_FINGERS-1:0] status_vec;
    logic [NUM_FINGERS-1:0] flip_vec;
    logic [NUM_FINGERS-1:0] cnt_zero_vec;

    logic seen_valid_q, seen_valid_d;
    logic status_changed_q, status_changed_d;
    logic hand_stable_q, hand_stable_d;

    assign sample_arr[THUMB]  = thumb_sample;
    assign sample_arr[INDEX]  = index_sample;
    assign sample_arr[MIDDLE] = middle_sample;
    assign sample_arr[RING]   = ring_sample;
    assign sample_arr[PINKY]  = pinky_sample;

    for (genvar f = 0; f < NUM_FINGERS; f++) begin : g_finger
        finger_debounce #(
            .ADC_W        (ADC_W),
            .BEND_HI      (BEND_HI),
            .BEND_LO      (BEND_LO),
            .STABLE_COUNT (STABLE_COUNT)
        ) u_deb (
            .clk            (clk),
            .rst            (rst),
            .sample_valid_i (sample_valid),
            .sample_i       (sample_arr[f]),
            .status_o       (status_vec[f]),
            .flip_o         (flip_vec[f]),
            .cnt_zero_o     (cnt_zero_vec[f])
        );
    end

    // Hand-stable uses next-state counters so it lines up with the status bits it describes.
    assign seen_valid_d     = seen_valid_q | sample_valid;
    assign status_changed_d = |flip_vec;
    assign hand_stable_d    = seen_valid_d & (&cnt_zero_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_valid_q     <= 1'b0;
            status_changed_q <= 1'b0;
            hand_stable_q    <= 1'b0;
        end else begin
            seen_valid_q     <= seen_valid_d;
            status_changed_q <= status_changed_d;
            hand_stable_q    <= hand_stable_d;
        end
    end

    assign thumb_status   = status_vec[THUMB];
    assign index_status   = status_vec[INDEX];
    assign middle_status  = status_vec[MIDDLE];
    assign ring_status    = status_vec[RING];
    assign pinky_status   = status_vec[PINKY];
    assign status_changed = status_changed_q;
    assign hand_stable    = hand_stable_q;
endmodule

// File: tb/tb_finger_status_conditioner.sv
// Directed table-driven bench for finger_status_conditioner at default parameters.
module tb_finger_status_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] thumb_sample, index_sample, middle_sample, ring_sample, pinky_sample;
    logic       thumb_status, index_status, middle_status, ring_status, pinky_status;
    logic       status_changed, hand_stable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    finger_status_conditioner dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .thumb_sample   (thumb_sample),
        .index_sample   (index_sample),
        .middle_sample  (middle_sample),
        .ring_sample    (ring_sample),
        .pinky_sample   (pinky_sample),
        .thumb_status   (thumb_status),
        .index_status   (index_status),
        .middle_status  (middle_status),
        .ring_status    (ring_status),
        .pinky_status   (pinky_status),
        .status_changed (status_changed),
        .hand_stable    (hand_stable)
    );

    typedef struct {
        logic       v;
        logic [7:0] th, ix, mi, ri, pi;
        logic [4:0] st;   // {pinky, ring, middle, index, thumb}
        logic       chg;
        logic       stab;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] th, logic [7:0] ix, logic [7:0] mi,
                                logic [7:0] ri, logic [7:0] pi, logic [4:0] st,
                                logic chg, logic stab);
        vec_t r;
        r.v = v; r.th = th; r.ix = ix; r.mi = mi; r.ri = ri; r.pi = pi;
        r.st = st; r.chg = chg; r.stab = stab;
        return r;
    endfunction

    function automatic logic [4:0] st_vec();
        return {pinky_status, ring_status, middle_status, index_status, thumb_status};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] th, input logic [7:0] ix,
                         input logic [7:0] mi, input logic [7:0] ri, input logic [7:0] pi);
        @(negedge clk);
        sample_valid  = v;
        thumb_sample  = th;
        index_sample  = ix;
        middle_sample = mi;
        ring_sample   = ri;
        pinky_sample  = pi;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] st, input logic chg, input logic stab);
        chk({tag, ".status"}, 32'(st_vec()), 32'(st));
        chk({tag, ".changed"}, 32'(status_changed), 32'(chg));
        chk({tag, ".stable"}, 32'(hand_stable), 32'(stab));
    endtask

    initial begin
        // Scenario 2: thumb bends after the third strobe.
        tbl.push_back(mk(1, 200, 50, 50, 50, 50, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 200, 50, 50, 50, 50, 5'b00000, 0, 0));
        tbl.push_back(mk(1, 200, 50, 50, 50, 50, 5'b00001, 1, 1));
        // Scenario 3: bend index, dead band holds it, then release.
        tbl.push_back(mk(1, 200, 200, 50, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 200, 50, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 200, 50, 50, 50, 5'b00011, 1, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 200, 128, 50, 50, 50, 5'b00011, 0, 1));
        tbl.push_back(mk(1, 200, 90, 50, 50, 50, 5'b00011, 0, 0));
        tbl.push_back(mk(1, 200, 90, 50, 50, 50, 5'b00011, 0, 0));
        tbl.push_back(mk(1, 200, 90, 50, 50, 50, 5'b00001, 1, 1));
        // Scenario 4: a single agreeing sample clears the middle counter.
        tbl.push_back(mk(1, 200, 50, 200, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 50, 200, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 50, 50, 50, 50, 5'b00001, 0, 1));
        tbl.push_back(mk(1, 200, 50, 200, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 50, 200, 50, 50, 5'b00001, 0, 0));
        tbl.push_back(mk(1, 200, 50, 200, 50, 50, 5'b00101, 1, 1));
        // Scenario 5: ring strobes separated by idle gaps.
        tbl.push_back(mk(1, 200, 50, 200, 200, 50, 5'b00101, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00101, 0, 0));
        tbl.push_back(mk(1, 200, 50, 200, 200, 50, 5'b00101, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b00101, 0, 0));
        tbl.push_back(mk(1, 200, 50, 200, 200, 50, 5'b01101, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'b01101, 0, 1));

        rst = 1'b1;
        sample_valid = 1'b0;
        thumb_sample = '0; index_sample = '0; middle_sample = '0;
        ring_sample = '0; pinky_sample = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", 5'b00000, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: idle after reset.
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0);
        chk_all("idle", 5'b00000, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].th, tbl[i].ix, tbl[i].mi, tbl[i].ri, tbl[i].pi);
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].chg, tbl[i].stab);
        end

        // Scenario 6: from reset, all five fingers flip together.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("rst2", 5'b00000, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 255, 255, 255, 255, 255);
        chk_all("all_s1", 5'b00000, 0, 0);
        drive(1, 255, 255, 255, 255, 255);
        chk_all("all_s2", 5'b00000, 0, 0);
        drive(1, 255, 255, 255, 255, 255);
        chk_all("all_s3", 5'b11111, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_all("all_pulse_end", 5'b11111, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        chk_all("rel_s1", 5'b11111, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk_all("rel_s2", 5'b11111, 0, 0);

        // Asynchronous reset mid-debounce, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 5'b00000, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Partial counts must be gone: a single disagreeing strobe cannot flip.
        drive(1, 255, 255, 255, 255, 255);
        chk_all("post_rst_s1", 5'b00000, 0, 0);
        drive(1, 255, 255, 255, 255, 255);
        chk_all("post_rst_s2", 5'b00000, 0, 0);
        drive(1, 255, 255, 255, 255, 255);
        chk_all("post_rst_s3", 5'b11111, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
